// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// It issues one command at a time, holds the ALU inputs for the command's latency and returns a one-cycle response.
module alu_req_arbiter #(
   parameter int WIDTH     = 8,
   parameter int CMD_W     = 4,
   parameter int LAT       = 1,
   parameter int MUL_LAT   = 2,
   parameter int MUL_CMD_A = 9,
   parameter int MUL_CMD_B = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [1:0]         REQ_VALID,
   output logic [1:0]         REQ_READY,
   input  logic [WIDTH-1:0]   REQ0_OPA,
   input  logic [WIDTH-1:0]   REQ1_OPA,
   input  logic [WIDTH-1:0]   REQ0_OPB,
   input  logic [WIDTH-1:0]   REQ1_OPB,
   input  logic [CMD_W-1:0]   REQ0_CMD,
   input  logic [CMD_W-1:0]   REQ1_CMD,
   input  logic [1:0]         REQ_MODE,
   input  logic [1:0]         REQ_CIN,
   output logic [1:0]         RSP_VALID,
   output logic [2*WIDTH-1:0] RSP_RES,
   output logic [5:0]         RSP_FLAGS,
   output logic [WIDTH-1:0]   ALU_OPA,
   output logic [WIDTH-1:0]   ALU_OPB,
   output logic [CMD_W-1:0]   ALU_CMD,
   output logic               ALU_MODE,
   output logic               ALU_CIN,
   output logic               ALU_CE,
   output logic [1:0]         ALU_INP_VALID,
   input  logic [2*WIDTH-1:0] ALU_RES,
   input  logic [5:0]         ALU_FLAGS
);

   localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               last_grant_r;
   logic               owner_r;
   logic               grant_id_s;
   logic [1:0]         req_ready_s;
   logic               accept_s;
   logic               capture_s;
   logic [WIDTH-1:0]   sel_opa_s;
   logic [WIDTH-1:0]   sel_opb_s;
   logic [CMD_W-1:0]   sel_cmd_s;
   logic               sel_mode_s;
   logic               sel_cin_s;

   function automatic logic is_mul_cmd(input logic mode, input logic [CMD_W-1:0] cmd);
      return mode && ((cmd == CMD_W'(MUL_CMD_A)) || (cmd == CMD_W'(MUL_CMD_B)));
   endfunction

   // Arbitration, next-state decode and request field selection.
   always_comb begin
      next_state_s = state_r;
      grant_id_s   = 1'b0;
      req_ready_s  = 2'b00;
      accept_s     = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // On a tie the requester that did not win last time goes first.
            if (REQ_VALID == 2'b11) begin
               grant_id_s = ~last_grant_r;
            end else if (REQ_VALID == 2'b10) begin
               grant_id_s = 1'b1;
            end else begin
               grant_id_s = 1'b0;
            end
            if (REQ_VALID != 2'b00) begin
               req_ready_s  = grant_id_s ? 2'b10 : 2'b01;
               accept_s     = 1'b1;
               next_state_s = ST_ISSUE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            next_state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_r == CNT_W'(1)) begin
               capture_s    = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
      sel_opa_s  = grant_id_s ? REQ1_OPA : REQ0_OPA;
      sel_opb_s  = grant_id_s ? REQ1_OPB : REQ0_OPB;
      sel_cmd_s  = grant_id_s ? REQ1_CMD : REQ0_CMD;
      sel_mode_s = REQ_MODE[grant_id_s];
      sel_cin_s  = REQ_CIN[grant_id_s];
   end

   // Ready must read 0 while reset is asserted even though state already reads IDLE.
   assign REQ_READY = RST ? req_ready_s : 2'b00;

   // State, latency counter, ALU drive and response capture.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         last_grant_r  <= 1'b1;
         owner_r       <= 1'b0;
         RSP_VALID     <= 2'b00;
         RSP_RES       <= '0;
         RSP_FLAGS     <= 6'b000000;
         ALU_OPA       <= '0;
         ALU_OPB       <= '0;
         ALU_CMD       <= '0;
         ALU_MODE      <= 1'b0;
         ALU_CIN       <= 1'b0;
         ALU_CE        <= 1'b0;
         ALU_INP_VALID <= 2'b00;
      end else begin
         state_r   <= next_state_s;
         RSP_VALID <= 2'b00;
         if (accept_s) begin
            ALU_OPA       <= sel_opa_s;
            ALU_OPB       <= sel_opb_s;
            ALU_CMD       <= sel_cmd_s;
            ALU_MODE      <= sel_mode_s;
            ALU_CIN       <= sel_cin_s;
            ALU_CE        <= 1'b1;
            ALU_INP_VALID <= 2'b11;
            owner_r       <= grant_id_s;
            last_grant_r  <= grant_id_s;
         end else if (state_r == ST_ISSUE) begin
            cnt_r <= is_mul_cmd(ALU_MODE, ALU_CMD) ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
         end else if (capture_s) begin
            RSP_RES       <= ALU_RES;
            RSP_FLAGS     <= ALU_FLAGS;
            RSP_VALID     <= owner_r ? 2'b10 : 2'b01;
            ALU_CE        <= 1'b0;
            ALU_INP_VALID <= 2'b00;
            cnt_r         <= '0;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance between two independent requesters, for example two stimulus or compute masters.
- Accepts one operation at a time via valid/ready, with round-robin arbitration.
- Drives the ALU operand/control inputs and holds them stable for the command's latency.
- Captures RES and the flags, and returns them to the originating requester as a one-cycle response pulse.

Parameters:
WIDTH, 8, operand width; RES is 2*WIDTH.
CMD_W, 4, command width.
LAT, 1, ALU latency in cycles for ordinary commands.
MUL_LAT, 2, ALU latency for multiply commands.
MUL_CMD_A, 9, first arithmetic-mode multiply command code.
MUL_CMD_B, 10, second arithmetic-mode multiply command code.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
REQ_VALID  in  2  per-requester request valid; bit i = requester i.
REQ_READY  out  2  per-requester accept, at most one bit high.
REQ0_OPA, REQ1_OPA  in  WIDTH  operand A.
REQ0_OPB, REQ1_OPB  in  WIDTH  operand B.
REQ0_CMD, REQ1_CMD  in  CMD_W  command.
REQ_MODE  in  2  per-requester mode; 1 = arithmetic, 0 = logical.
REQ_CIN  in  2  per-requester carry-in.
RSP_VALID  out  2  one-cycle response pulse to requester i.
RSP_RES  out  2*WIDTH  captured result, shared by both requesters.
RSP_FLAGS  out  6  captured {ERR,COUT,OFLOW,G,E,L}.
ALU_OPA, ALU_OPB  out  WIDTH  ALU operands.
ALU_CMD  out  CMD_W  ALU command.
ALU_MODE, ALU_CIN, ALU_CE  out  1  ALU controls.
ALU_INP_VALID  out  2  ALU operand-valid.
ALU_RES  in  2*WIDTH  ALU result.
ALU_FLAGS  in  6  {ERR,COUT,OFLOW,G,E,L} from the ALU.

Behaviour:
Reset (RST low, asynchronous):
- All outputs go to 0, state goes to IDLE, counter clears.
- last_grant goes to 1, so requester 0 wins the first tie.
- Reset asserted mid-operation aborts the operation; no RSP_VALID is ever issued for it.

FSM states:
- IDLE:
  - REQ_READY[i] is high combinationally for the winner.
  - Winner rule: the single valid requester; if both are valid, the requester that is not last_grant.
  - A transfer occurs when REQ_VALID[i] and REQ_READY[i] are both high at a rising edge.
  - On transfer: latch OPA/OPB/CMD/MODE/CIN and the owner id, set last_grant to i, go to ISSUE.
  - REQ_READY is 0 in every state other than IDLE.
- ISSUE (1 cycle):
  - ALU_* driven from the latched operands, ALU_INP_VALID = 2'b11, ALU_CE = 1.
  - Counter loads MUL_LAT if MODE = 1 and CMD is MUL_CMD_A or MUL_CMD_B; otherwise it loads LAT.
  - Next state: WAIT.
- WAIT:
  - ALU inputs, INP_VALID = 11 and CE = 1 are all held unchanged.
  - Counter decrements each edge.
  - At the edge where the counter equals 1: register ALU_RES into RSP_RES and ALU_FLAGS into RSP_FLAGS, set RSP_VALID[owner] high for exactly the next cycle, and go to IDLE.

Outputs and timing:
- In IDLE, ALU_CE = 0 and ALU_INP_VALID = 00; ALU_OPA/OPB/CMD/MODE/CIN keep their last values.
- End-to-end latency from the accept edge E0 to RSP_VALID high is (1+lat) edges: RSP_VALID is high in the cycle after edge E(1+lat).
  - LAT = 1 gives 2 cycles; MUL_LAT = 2 gives 3 cycles.
- A new accept is allowed in the same cycle that RSP_VALID is high, giving back-to-back throughput of one operation per (2+lat) cycles.
- RSP_RES and RSP_FLAGS hold their values until the next capture.
- ERR is passed through unmodified; the arbiter does not interpret it.

Requester obligations:
- REQ_VALID and the request fields must stay stable until accepted.
- A request withdrawn before acceptance is simply not issued.

Fairness:
- With both requesters continuously valid, grants strictly alternate 0, 1, 0, 1, …

Test Plan:
1. Reset release, only REQ_VALID = 01, MODE = 1, CMD = 0 (ADD), OPA = 8'h0F, OPB = 8'h01 -> REQ_READY = 01 at accept; ALU_INP_VALID = 11 one cycle later; RSP_VALID = 01 two cycles after accept with RSP_RES = 16'h0010.
2. Both requesters valid from reset, requester 1 doing ADD 3+4 -> requester 0 granted first; requester 1 granted in the RSP cycle; RSP_VALID = 10 with RES = 7; grants alternate over 6 back-to-back ops.
3. MODE = 1, CMD = 9, OPA = 3, OPB = 4 -> ALU inputs held for 3 cycles; RSP at accept + 3 with the ALU's value; INP_VALID never drops while busy.
4. RST pulsed low during WAIT -> all outputs 0 immediately; no RSP_VALID afterwards; next request granted to requester 0 on a tie.
5. Requester 1 asserts a request while requester 0's operation is in WAIT -> REQ_READY stays 00 until IDLE, then requester 1 is accepted; RSP_RES of the first op is unchanged until the second capture.
6. ALU_FLAGS = 6'b100000 (ERR) during capture -> RSP_FLAGS = 6'b100000 delivered to the owner; the arbiter returns to IDLE normally.
